// File: rtl/divider.sv
// ============================================================================
// Module   : divider
// Purpose  : Iterative unsigned restoring divider. One quotient bit per clock,
//            start/done pulse handshake, results held until the next result.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB,
  // so after WIDTH steps this register holds the quotient.
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dvs_q;
  // The partial remainder is always below the divisor after each step, so
  // its top bit is zero and only the shifted value needs WIDTH+1 bits.
  logic [WIDTH-1:0]   rem_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   r_q;
  logic               dbz_q;

  logic [WIDTH:0]     rem_sh;
  logic               take;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   dvd_d;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    take   = (rem_sh >= {1'b0, dvs_q});
    rem_d  = take ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
    dvd_d  = {dvd_q[WIDTH-2:0], take};
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (b == '0) begin
              // Zero divisor: result lands now; done_q stays low so the
              // DONE state raises the pulse on its following edge.
              q_q     <= '1;
              r_q     <= a;
              dbz_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              dvd_q   <= a;
              dvs_q   <= b;
              rem_q   <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST) begin
            q_q     <= dvd_d;
            r_q     <= rem_d;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // done_q low here means we arrived via the zero-divisor shortcut.
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dbz  = dbz_q;

endmodule

`default_nettype wire
